// File: rtl/stack_ctrl.sv
// stack_ctrl - hardware stack controller for the 8-bit pipelined processor.
// Owns the stack pointer (architectural R3) and sequences multi-entry PUSH/POP
// bursts to data memory, one entry per cycle, with overflow/underflow
// detection against the window [SP_MIN, SP_INIT].
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   op_valid/op_ready request handshake; op_ready is high only in IDLE
//   op_push, op_count operation kind (1 = push) and entry count 0..MAXBURST
//   push_data         entries to push, entry k at [k*DW +: DW], entry 0 first
//   pop_data          popped entries, entry 0 = old top; valid while done=1
//   mem_*             memory port; mem_rdata is valid in the same cycle as mem_re
//   sp                current stack pointer
//   sp_wr_en/data     architectural write-back to R3
//   done              one-cycle completion pulse
//   fault_ovf/unf     pulse with done on a rejected push/pop
//
// state | meaning
// IDLE  | waiting for an operation or an R3 write-back
// PUSH  | writing one entry per cycle at sp, sp post-decrements
// POP   | reading one entry per cycle at sp+1, sp pre-increments
// DONE  | completion pulse; pending R3 write-back lands on exit
module stack_ctrl #(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter logic [AW-1:0] SP_INIT = 8'hFF,
  parameter logic [AW-1:0] SP_MIN  = 8'hC0,
  parameter int MAXBURST = 4,
  parameter int CW = $clog2(MAXBURST + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   op_valid,
  output logic                   op_ready,
  input  logic                   op_push,
  input  logic [CW-1:0]          op_count,
  input  logic [MAXBURST*DW-1:0] push_data,
  output logic [MAXBURST*DW-1:0] pop_data,
  output logic [AW-1:0]          mem_addr,
  output logic                   mem_we,
  output logic                   mem_re,
  output logic [DW-1:0]          mem_wdata,
  input  logic [DW-1:0]          mem_rdata,
  output logic [AW-1:0]          sp,
  input  logic                   sp_wr_en,
  input  logic [AW-1:0]          sp_wr_data,
  output logic                   done,
  output logic                   fault_ovf,
  output logic                   fault_unf
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PUSH = 2'd1,
    S_POP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                state, state_nxt;
  logic [AW-1:0]         sp_q;
  logic [CW-1:0]         remain;
  logic [CW-1:0]         idx;
  logic [MAXBURST*DW-1:0] push_buf;
  logic [MAXBURST*DW-1:0] pop_buf;
  logic                  ovf_q, unf_q;
  logic                  pend_vld;
  logic [AW-1:0]         pend_data;
  logic                  accept;
  logic                  push_ok, pop_ok;
  logic [AW:0]           sp_ext;

  assign sp       = sp_q;
  assign pop_data = pop_buf;
  assign sp_ext   = {1'b0, sp_q};

  // Push check is sp - n + 1 >= SP_MIN, rearranged so nothing goes negative
  // when sp has been written below the window by software.
  assign push_ok = (sp_ext + (AW+1)'(1)) >= ({1'b0, SP_MIN} + (AW+1)'(op_count));
  assign pop_ok  = (sp_ext + (AW+1)'(op_count)) <= {1'b0, SP_INIT};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    op_ready  = 1'b0;
    accept    = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    done      = 1'b0;
    fault_ovf = 1'b0;
    fault_unf = 1'b0;
    case (state)
      S_IDLE: begin
        // an R3 write-back owns the cycle, so no operation is accepted
        op_ready = !sp_wr_en;
        accept   = op_valid && !sp_wr_en;
        if (accept) begin
          if (op_count == '0)  state_nxt = S_DONE;
          else if (op_push)    state_nxt = push_ok ? S_PUSH : S_DONE;
          else                 state_nxt = pop_ok  ? S_POP  : S_DONE;
        end
      end
      S_PUSH: begin
        mem_we    = 1'b1;
        mem_addr  = sp_q;
        mem_wdata = push_buf[idx*DW +: DW];
        if (remain == CW'(1)) state_nxt = S_DONE;
      end
      S_POP: begin
        mem_re   = 1'b1;
        mem_addr = sp_q + AW'(1);
        if (remain == CW'(1)) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        fault_ovf = ovf_q;
        fault_unf = unf_q;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp_q      <= SP_INIT;
      remain    <= '0;
      idx       <= '0;
      push_buf  <= '0;
      pop_buf   <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      pend_vld  <= 1'b0;
      pend_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (sp_wr_en) begin
            sp_q <= sp_wr_data;
          end else if (op_valid) begin
            push_buf <= push_data;
            remain   <= op_count;
            idx      <= '0;
            ovf_q    <= (op_count != '0) &&  op_push && !push_ok;
            unf_q    <= (op_count != '0) && !op_push && !pop_ok;
          end
        end
        S_PUSH, S_POP: begin
          if (state == S_PUSH) begin
            sp_q <= sp_q - AW'(1);
          end else begin
            pop_buf[idx*DW +: DW] <= mem_rdata;
            sp_q <= sp_q + AW'(1);
          end
          remain <= remain - CW'(1);
          idx    <= idx + CW'(1);
          if (sp_wr_en) begin
            pend_vld  <= 1'b1;
            pend_data <= sp_wr_data;
          end
        end
        S_DONE: begin
          ovf_q    <= 1'b0;
          unf_q    <= 1'b0;
          pend_vld <= 1'b0;
          // a write-back arriving in DONE is the newest one, so it wins
          if (sp_wr_en)      sp_q <= sp_wr_data;
          else if (pend_vld) sp_q <= pend_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
module tb_stack_ctrl;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int CW = 3;
  localparam logic [7:0] P_INIT = 8'h7F;
  localparam logic [7:0] P_MIN  = 8'h7C;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          op_valid = 1'b0;
  logic          op_ready;
  logic          op_push = 1'b0;
  logic [CW-1:0] op_count = '0;
  logic [31:0]   push_data = '0;
  logic [31:0]   pop_data;
  logic [7:0]    mem_addr;
  logic          mem_we, mem_re;
  logic [7:0]    mem_wdata, mem_rdata;
  logic [7:0]    sp;
  logic          sp_wr_en = 1'b0;
  logic [7:0]    sp_wr_data = '0;
  logic          done, fault_ovf, fault_unf;

  stack_ctrl #(.AW(AW), .DW(DW), .SP_INIT(P_INIT), .SP_MIN(P_MIN), .MAXBURST(MB), .CW(CW)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .op_push(op_push),
    .op_count(op_count), .push_data(push_data), .pop_data(pop_data), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_re(mem_re), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .sp(sp), .sp_wr_en(sp_wr_en), .sp_wr_data(sp_wr_data), .done(done),
    .fault_ovf(fault_ovf), .fault_unf(fault_unf)
  );

  always #5 clk = ~clk;

  // environment memory
  logic [7:0] mem [256] = '{default: 8'h00};
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  // model state
  int         checks = 0;
  int         errors = 0;
  logic [7:0] m_mem [256] = '{default: 8'h00};
  int         m_sp = 32'h7F;
  bit         chk_en = 1'b0;
  logic [31:0] last_pop = '0;
  logic       last_ovf = 1'b0, last_unf = 1'b0;

  typedef struct {
    logic we, re, done, ovf, unf, chk_pop;
    logic [7:0] addr, wdata, spv;
    logic [31:0] pop;
  } rec_t;
  rec_t exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_q.size() > 0) begin
        rec_t r;
        r = exp_q.pop_front();
        chk("busy_ready", op_ready, 0);
        chk("busy_we", mem_we, r.we);
        chk("busy_re", mem_re, r.re);
        chk("busy_done", done, r.done);
        chk("busy_ovf", fault_ovf, r.ovf);
        chk("busy_unf", fault_unf, r.unf);
        chk("busy_sp", sp, r.spv);
        if (r.we || r.re) chk("busy_addr", mem_addr, r.addr);
        if (r.we) chk("busy_wdata", mem_wdata, r.wdata);
        if (r.chk_pop) chk("pop_data", pop_data, r.pop);
        if (r.done) begin
          last_pop = pop_data;
          last_ovf = fault_ovf;
          last_unf = fault_unf;
        end
      end else begin
        chk("idle_ready", op_ready, !sp_wr_en);
        chk("idle_we", mem_we, 0);
        chk("idle_re", mem_re, 0);
        chk("idle_done", done, 0);
        chk("idle_fault", {fault_ovf, fault_unf}, 0);
        chk("idle_sp", sp, m_sp[7:0]);
      end
    end
  end

  // all tasks start and end one time unit after a rising edge
  task automatic set_sp(input logic [7:0] v);
    sp_wr_en = 1'b1;
    sp_wr_data = v;
    @(posedge clk); #1;
    sp_wr_en = 1'b0;
    m_sp = v;
  endtask

  task automatic do_op(input bit push, input int n, input logic [31:0] d, input bit wr_mid);
    rec_t r;
    int sp0, sp_end, ncyc;
    bit legal;
    logic [31:0] pexp;
    sp0 = m_sp;
    op_valid = 1'b1;
    op_push = push;
    op_count = CW'(n);
    push_data = d;
    @(posedge clk); #1;
    op_valid = 1'b0;
    if (push) legal = (sp0 - n + 1) >= int'(P_MIN);
    else      legal = (sp0 + n) <= int'(P_INIT);
    sp_end = sp0;
    pexp = '0;
    if (legal && n > 0) begin
      for (int j = 0; j < n; j++) begin
        r = '{default: 0};
        r.we = push;
        r.re = !push;
        r.addr = push ? 8'(sp0 - j) : 8'(sp0 + 1 + j);
        r.wdata = d[j*8 +: 8];
        r.spv = push ? 8'(sp0 - j) : 8'(sp0 + j);
        exp_q.push_back(r);
        if (push) m_mem[sp0 - j] = d[j*8 +: 8];
        else      pexp[j*8 +: 8] = m_mem[sp0 + 1 + j];
      end
      sp_end = push ? sp0 - n : sp0 + n;
    end
    r = '{default: 0};
    r.done = 1'b1;
    r.spv = 8'(sp_end);
    r.ovf = (n > 0) && push && !legal;
    r.unf = (n > 0) && !push && !legal;
    r.chk_pop = (n > 0) && !push && legal;
    r.pop = pexp;
    exp_q.push_back(r);
    ncyc = (legal && n > 0) ? n + 1 : 1;
    for (int k = 1; k <= ncyc; k++) begin
      if (wr_mid && k == 2) begin
        sp_wr_en = 1'b1;
        sp_wr_data = 8'h50;
      end
      @(posedge clk); #1;
      sp_wr_en = 1'b0;
    end
    m_sp = wr_mid ? 32'h50 : sp_end;
    chk("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    // 1: reset values, then reset during a push burst
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sp", sp, 8'h7F);
    chk("rst_pop", pop_data, 0);
    chk("rst_addr", {mem_addr, mem_wdata, mem_we, mem_re, done}, 0);
    rst = 1'b1;
    #1;
    chk("rel_ready", op_ready, 1);
    chk("rel_sp", sp, 8'h7F);
    op_valid = 1'b1;
    op_push = 1'b1;
    op_count = 3'd3;
    push_data = 32'h0033_2211;
    @(posedge clk); #1;
    op_valid = 1'b0;
    chk("c1_we", mem_we, 1);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("abort_we", mem_we, 0);
    chk("abort_sp", sp, 8'h7F);
    @(posedge clk); #1;
    chk("abort_mem7f", mem[8'h7F], 8'h11);
    chk("abort_mem7e", mem[8'h7E], 8'h00);
    chk("abort_mem7d", mem[8'h7D], 8'h00);
    rst = 1'b1;
    m_mem[8'h7F] = 8'h11;
    m_sp = 32'h7F;
    @(posedge clk); #1;
    chk_en = 1'b1;

    // 2: push two
    do_op(1'b1, 2, 32'h0000_B2A1, 1'b0);
    chk("s2_mem7f", mem[8'h7F], 8'hA1);
    chk("s2_mem7e", mem[8'h7E], 8'hB2);
    chk("s2_sp", sp, 8'h7D);

    // 3: pop two
    do_op(1'b0, 2, 32'h0, 1'b0);
    chk("s3_pop", last_pop[15:0], 16'hA1B2);
    chk("s3_sp", sp, 8'h7F);

    // 4: fill window, overflow, underflow
    do_op(1'b1, 4, 32'h4433_2211, 1'b0);
    chk("s4_mem7c", mem[8'h7C], 8'h44);
    chk("s4_sp", sp, 8'h7B);
    do_op(1'b1, 1, 32'h0000_00EE, 1'b0);
    chk("s4_ovf", last_ovf, 1);
    chk("s4_sp_kept", sp, 8'h7B);
    chk("s4_mem7b", mem[8'h7B], 8'h00);
    set_sp(8'h7F);
    do_op(1'b0, 1, 32'h0, 1'b0);
    chk("s4_unf", last_unf, 1);

    // 5: write-back during a burst
    do_op(1'b1, 3, 32'h00C3_C2C1, 1'b1);
    chk("s5_mem7d", mem[8'h7D], 8'hC3);
    chk("s5_sp", sp, 8'h50);

    // 6: zero count, pop below window, push rejected from below window
    do_op(1'b1, 0, 32'hFFFF_FFFF, 1'b0);
    chk("s6_sp", sp, 8'h50);
    do_op(1'b0, 4, 32'h0, 1'b0);
    chk("s6_pop_sp", sp, 8'h54);
    do_op(1'b1, 2, 32'h0000_9988, 1'b0);
    chk("s6_ovf", last_ovf, 1);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
